// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 VGA timing constants, the position type and
//               a small range-decode helper. Used by the timing generator and
//               by overlay renderers that need the same frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_DISPLAY     = 640;
    localparam int unsigned H_FP          = 16;
    localparam int unsigned H_SYNC        = 96;
    localparam int unsigned H_BP          = 48;
    localparam int unsigned H_TOTAL       = H_DISPLAY + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int unsigned V_DISPLAY     = 480;
    localparam int unsigned V_FP          = 10;
    localparam int unsigned V_SYNC        = 2;
    localparam int unsigned V_BP          = 33;
    localparam int unsigned V_TOTAL       = V_DISPLAY + V_FP + V_SYNC + V_BP;

    // System clocks per pixel (100 MHz -> 25 MHz pixel rate)
    localparam int unsigned CLK_PER_PIXEL = 4;

    localparam int unsigned POS_W         = 11;
    typedef logic [POS_W-1:0] pos_t;

    // Unsigned inclusive range test used for sync-pulse decode
    function automatic logic in_range(input pos_t v, input pos_t lo, input pos_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_tick
// Description : Free-running clock divider producing the pixel advance enable.
//               o_advance is high in the last divider state, so the position
//               registers downstream move on the edge that wraps the divider.
// Ports       : clk       - system clock
//               reset_n   - synchronous active-low reset (divider -> 0)
//               o_advance - one-clk enable, once every DIV_RATIO clocks
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV_RATIO = CLK_PER_PIXEL
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_advance
);

    localparam int unsigned     DIV_W      = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV_RATIO - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_advance = (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Keeps the pixel/line counters and
//               decodes sync and blanking. Every output is registered and
//               loaded from the *next* position on the advance edge, so
//               position, syncs and video_on never skew against each other.
// Ports       : clk, reset_n             - clock, synchronous active-low reset
//               hsync, vsync             - active-low sync pulses
//               video_on                 - inside the visible area
//               p_tick                   - first cycle of a new position
//               line_start, frame_start  - p_tick qualified by x==0 / (0,0)
//               pixel_x, pixel_y         - current position
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_DISPLAY,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_PULSE  = H_SYNC,
    parameter int unsigned H_BACK   = H_BP,
    parameter int unsigned V_ACTIVE = V_DISPLAY,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_PULSE  = V_SYNC,
    parameter int unsigned V_BACK   = V_BP
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        p_tick,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam pos_t c_h_last     = pos_t'(H_ACTIVE + H_FRONT + H_PULSE + H_BACK - 1);
    localparam pos_t c_v_last     = pos_t'(V_ACTIVE + V_FRONT + V_PULSE + V_BACK - 1);
    localparam pos_t c_h_active   = pos_t'(H_ACTIVE);
    localparam pos_t c_v_active   = pos_t'(V_ACTIVE);
    localparam pos_t c_hs_first   = pos_t'(H_ACTIVE + H_FRONT);
    localparam pos_t c_hs_last    = pos_t'(H_ACTIVE + H_FRONT + H_PULSE - 1);
    localparam pos_t c_vs_first   = pos_t'(V_ACTIVE + V_FRONT);
    localparam pos_t c_vs_last    = pos_t'(V_ACTIVE + V_FRONT + V_PULSE - 1);

    logic w_advance;
    logic w_x_wrap;
    logic w_y_wrap;
    pos_t w_x_next;
    pos_t w_y_next;

    pos_t r_x;
    pos_t r_y;
    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_p_tick;
    logic r_line_start;
    logic r_frame_start;

    vga_pixel_tick #(
        .DIV_RATIO (CLK_PER_PIXEL)
    ) u_pixel_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .o_advance (w_advance)
    );

    // Next raster position; only committed on an advance edge
    always_comb begin
        w_x_wrap = (r_x == c_h_last);
        w_y_wrap = (r_y == c_v_last);
        w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_next = r_y;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? '0 : r_y + 1'b1;
        end
    end

    // Reset parks the raster on the last position of a frame so the first
    // advance lands on (0,0) and raises frame_start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x           <= c_h_last;
            r_y           <= c_v_last;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_p_tick      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_p_tick      <= w_advance;
            r_line_start  <= w_advance && w_x_wrap;
            r_frame_start <= w_advance && w_x_wrap && w_y_wrap;
            if (w_advance) begin
                r_x        <= w_x_next;
                r_y        <= w_y_next;
                r_hsync    <= !in_range(w_x_next, c_hs_first, c_hs_last);
                r_vsync    <= !in_range(w_y_next, c_vs_first, c_vs_last);
                r_video_on <= (w_x_next < c_h_active) && (w_y_next < c_v_active);
            end
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign p_tick      = r_p_tick;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Horizontal timing is
//               the real 800-pixel line; the vertical geometry is shrunk so a
//               whole frame fits in a short run. The reference model derives
//               every output from the number of clocks since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned VS_FIRST = VA + VF;
    localparam int unsigned VS_LAST  = VA + VF + VS - 1;
    localparam int unsigned LINE_CLKS  = 3200;
    localparam int unsigned FRAME_CLKS = LINE_CLKS * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync, vsync, video_on, p_tick, line_start, frame_start;
    logic [10:0] pixel_x, pixel_y;

    int unsigned k = 0;   // rising edges with reset_n=1 since last reset edge
    int          total = 0;
    int          bad = 0;

    vga_timing_gen #(
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .V_PULSE  (VS),
        .V_BACK   (VB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) k <= reset_n ? k + 1 : 0;

    // Expected {x, y, hsync, vsync, video_on, p_tick, line_start, frame_start}
    // after kk clocks out of reset: one pixel per 4 clocks, first at clock 4.
    function automatic logic [27:0] model(input int unsigned kk);
        int unsigned n, lin, x, y;
        logic hs, vs, vo, pt, ls, fs;
        if (kk < 4) begin
            x  = 799;
            y  = VT - 1;
            pt = 1'b0;
        end else begin
            n   = kk / 4;
            lin = (n - 1) % (800 * VT);
            x   = lin % 800;
            y   = lin / 800;
            pt  = (kk % 4) == 0;
        end
        hs = !(x >= 656 && x <= 751);
        vs = !(y >= VS_FIRST && y <= VS_LAST);
        vo = (x < 640) && (y < VA);
        ls = pt && (x == 0);
        fs = ls && (y == 0);
        return {11'(x), 11'(y), hs, vs, vo, pt, ls, fs};
    endfunction

    function automatic logic [27:0] dut_vec();
        return {pixel_x, pixel_y, hsync, vsync, video_on, p_tick, line_start, frame_start};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dut_vec() !== model(0)) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(), model(0));
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
        end
        total++;
        if (pixel_x !== 11'd0 || pixel_y !== 11'd0 || video_on !== 1'b1 || frame_start !== 1'b1 ||
            line_start !== 1'b1 || p_tick !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            bad++;
            $display("FAIL first_advance got x=%0d y=%0d vo=%b fs=%b ls=%b pt=%b hs=%b vs=%b want 0 0 1 1 1 1 1 1",
                     pixel_x, pixel_y, video_on, frame_start, line_start, p_tick, hsync, vsync);
        end
    endtask

    task automatic test_line();
        int          hs_low = 0;
        int          ls_cnt = 0;
        int unsigned first_hs_x = 0;
        int unsigned ls_k = 0;
        int unsigned k0;
        logic        prev_pt;
        k0      = k;
        prev_pt = p_tick;
        for (int i = 1; i <= int'(LINE_CLKS); i++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL line k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
            total++;
            if (prev_pt && p_tick) begin
                bad++;
                $display("FAIL ptick_back_to_back k=%0d got=1 want=0", k);
            end
            prev_pt = p_tick;
            if (p_tick && !hsync && i < int'(LINE_CLKS)) begin
                if (hs_low == 0) first_hs_x = pixel_x;
                hs_low++;
            end
            if (line_start) begin
                ls_cnt++;
                ls_k = k;
            end
        end
        total++;
        if (hs_low != 96) begin
            bad++;
            $display("FAIL hsync_width got=%0d want=96", hs_low);
        end
        total++;
        if (first_hs_x != 656) begin
            bad++;
            $display("FAIL hsync_start got=%0d want=656", first_hs_x);
        end
        total++;
        if (ls_cnt != 1 || ls_k - k0 != LINE_CLKS) begin
            bad++;
            $display("FAIL line_period got count=%0d period=%0d want count=1 period=%0d",
                     ls_cnt, ls_k - k0, LINE_CLKS);
        end
    endtask

    task automatic test_frame();
        int          vs_low = 0, vo_cnt = 0, fs_cnt = 0, b_h = 0, b_v = 0, b_f = 0;
        int unsigned fs_at = 0;
        logic [10:0] px, py;
        logic        pvo;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL frame_entry k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
        end
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_first_start got=%b want=1", frame_start);
        end
        if (!vsync) vs_low++;
        if (video_on) vo_cnt++;
        px = pixel_x; py = pixel_y; pvo = video_on;
        for (int i = 1; i <= int'(FRAME_CLKS); i++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL frame k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
            if (frame_start) begin
                fs_cnt++;
                fs_at = i;
            end
            if (p_tick) begin
                if (i < int'(FRAME_CLKS)) begin
                    if (!vsync) vs_low++;
                    if (video_on) vo_cnt++;
                end
                if (px == 11'd639 && py < VA) begin
                    b_h++;
                    total++;
                    if (pvo !== 1'b1 || video_on !== 1'b0 || pixel_x !== 11'd640 || pixel_y !== py) begin
                        bad++;
                        $display("FAIL edge_639_640 y=%0d got vo %b->%b x=%0d want 1->0 x=640", py, pvo, video_on, pixel_x);
                    end
                end
                if (px == 11'd799 && py == VA - 1) begin
                    b_v++;
                    total++;
                    if (pixel_x !== 11'd0 || pixel_y !== 11'(VA) || video_on !== 1'b0) begin
                        bad++;
                        $display("FAIL edge_last_visible got x=%0d y=%0d vo=%b want 0 %0d 0", pixel_x, pixel_y, video_on, VA);
                    end
                end
                if (px == 11'd799 && py == VT - 1) begin
                    b_f++;
                    total++;
                    if (pixel_x !== 11'd0 || pixel_y !== 11'd0 || frame_start !== 1'b1) begin
                        bad++;
                        $display("FAIL edge_frame_wrap got x=%0d y=%0d fs=%b want 0 0 1", pixel_x, pixel_y, frame_start);
                    end
                end
                px = pixel_x; py = pixel_y; pvo = video_on;
            end
        end
        total++;
        if (vs_low != 800 * VS) begin
            bad++;
            $display("FAIL vsync_width got=%0d want=%0d", vs_low, 800 * VS);
        end
        total++;
        if (vo_cnt != 640 * VA) begin
            bad++;
            $display("FAIL visible_pixels got=%0d want=%0d", vo_cnt, 640 * VA);
        end
        total++;
        if (fs_cnt != 1 || fs_at != FRAME_CLKS) begin
            bad++;
            $display("FAIL frame_period got count=%0d at=%0d want count=1 at=%0d", fs_cnt, fs_at, FRAME_CLKS);
        end
        total++;
        if (b_h != int'(VA) || b_v != 1 || b_f != 1) begin
            bad++;
            $display("FAIL boundary_hits got h=%0d v=%0d f=%0d want %0d 1 1", b_h, b_v, b_f, VA);
        end
    endtask

    task automatic test_mid_reset();
        int unsigned target;
        int          guard = 0;
        int          cnt = 0;
        target  = 4 * (VS_FIRST * 800 + 701);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        while (k != target && guard < 30000) begin
            @(negedge clk);
            guard++;
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL mid_run k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
        end
        total++;
        if (k != target || pixel_x !== 11'd700 || pixel_y !== 11'(VS_FIRST) || hsync !== 1'b0 || vsync !== 1'b0) begin
            bad++;
            $display("FAIL mid_reach got k=%0d x=%0d y=%0d hs=%b vs=%b want k=%0d 700 %0d 0 0",
                     k, pixel_x, pixel_y, hsync, vsync, target, VS_FIRST);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (pixel_x !== 11'd799 || pixel_y !== 11'(VT - 1) || hsync !== 1'b1 || vsync !== 1'b1 ||
            video_on !== 1'b0 || p_tick !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b want 799 %0d 1 1 0 0",
                     pixel_x, pixel_y, hsync, vsync, video_on, p_tick, VT - 1);
        end
        do begin
            @(negedge clk);
            cnt++;
        end while (!p_tick && cnt < 8);
        total++;
        if (cnt != 4 || pixel_x !== 11'd0 || pixel_y !== 11'd0 || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL mid_first_advance got clks=%0d x=%0d y=%0d fs=%b want 4 0 0 1", cnt, pixel_x, pixel_y, frame_start);
        end
    endtask

    task automatic test_random_reset();
        int unsigned n;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1500, 50);
            repeat (n) begin
                @(negedge clk);
                total++;
                if (dut_vec() !== model(k)) begin
                    bad++;
                    $display("FAIL rand_run k=%0d got=%h want=%h", k, dut_vec(), model(k));
                end
            end
            reset_n = 1'b0;
            n = $urandom_range(3, 1);
            repeat (n) begin
                @(negedge clk);
                total++;
                if (dut_vec() !== model(k)) begin
                    bad++;
                    $display("FAIL rand_reset k=%0d got=%h want=%h", k, dut_vec(), model(k));
                end
            end
            reset_n = 1'b1;
        end
        repeat (12) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model(k)) begin
                bad++;
                $display("FAIL rand_tail k=%0d got=%h want=%h", k, dut_vec(), model(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        test_random_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 hsync  output  1  horizontal sync, active low.
REQ-005 vsync  output  1  vertical sync, active low.
REQ-006 video_on  output  1  high when the current position is inside the 640x480 visible area.
REQ-007 p_tick  output  1  one-clk pulse in the first cycle that a new pixel position is valid.
REQ-008 pixel_x  output  11  current horizontal count, 0..799.
REQ-009 pixel_y  output  11  current vertical count, 0..524.
REQ-010 line_start  output  1  one-clk pulse coincident with p_tick when pixel_x becomes 0.
REQ-011 frame_start  output  1  one-clk pulse coincident with p_tick when position becomes (0,0).

Function
REQ-012 A 2-bit divider SHALL increment every clk and wrap 3->0; the position advances on the edge where the divider equals 3 (one pixel per 4 clks, 25 MHz).
REQ-013 Horizontal timing SHALL be: display 0..639, front porch 640..655, sync 656..751, back porch 752..799; total 800.
REQ-014 Vertical timing SHALL be: display 0..479, front porch 480..489, sync 490..491, back porch 492..524; total 525.
REQ-015 On advance, pixel_x SHALL increment; at 799 it SHALL wrap to 0 and pixel_y SHALL increment; at (799,524) both SHALL wrap to (0,0).
REQ-016 hsync, vsync and video_on SHALL be registered and loaded on the same edge as pixel_x/pixel_y from the new position, so all outputs are mutually consistent in every cycle (zero skew).
REQ-017 hsync SHALL be 0 iff 656<=pixel_x<=751; vsync SHALL be 0 iff 490<=pixel_y<=491; video_on SHALL be 1 iff pixel_x<640 and pixel_y<480.
REQ-018 p_tick, line_start and frame_start SHALL be high for exactly one clk, only in the cycle immediately after an advance edge.
REQ-019 Outputs SHALL hold their values between advances; no output glitches or changes on non-advance edges except p_tick/line_start/frame_start returning to 0.
REQ-020 pixel_x/pixel_y widths SHALL be 11 bits with upper unused values never produced; counter compares SHALL be unsigned.

Reset
REQ-021 While reset_n=0 at a clk edge: divider=0, pixel_x=799, pixel_y=524, hsync=1, vsync=1, video_on=0, p_tick=0, line_start=0, frame_start=0.
REQ-022 The first advance after reset release SHALL occur on the 4th rising edge with reset_n=1, yielding (0,0), video_on=1, p_tick=line_start=frame_start=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame immediately and return to the REQ-021 state; no partial sync pulse SHALL persist.

Structure
REQ-024 Timing constants (H_DISPLAY, H_FP, H_SYNC, H_BP, H_TOTAL, V_DISPLAY, V_FP, V_SYNC, V_BP, V_TOTAL, CLK_PER_PIXEL=4) SHALL live in shared package vga_timing_pkg, also used by overlay renderers.
REQ-025 The divider SHALL be a sub-module vga_pixel_tick (outputs the advance enable); counters and sync decode stay in vga_timing_gen.

Verification
REQ-026 Reset then release -> outputs per REQ-021 for 3 clks; on 4th clk pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=vsync=1.
REQ-027 Run one line -> hsync low for exactly 96 p_ticks starting at pixel_x=656; line period exactly 3200 clks; line_start once per 3200 clks.
REQ-028 Run one frame -> vsync low for exactly 1600 p_ticks (lines 490-491); frame_start period 1,680,000 clks; 307,200 p_ticks with video_on=1 per frame.
REQ-029 Boundaries -> (639,y) video_on=1 then (640,y)=0; (799,479)->(0,480) with video_on=0; (799,524)->(0,0) with frame_start=1.
REQ-030 Assert reset_n=0 for 1 clk at pixel_x=700, pixel_y=490 (both syncs low) -> next cycle hsync=vsync=1, position (799,524); first advance 4 clks after release.
REQ-031 Every clk -> assert hsync/vsync/video_on equal the REQ-017 decode of current pixel_x/pixel_y, and p_tick never high on two consecutive clks.
